rf_envelope_detect: RTL and testbench
=====================================

// Module: rf_envelope_detect
// PURPOSE
//  Downstream consumer of the RF sample playback stream (one signed 16-bit RF sample per valid cycle).
//  Per scanline: optional DC removal, full-wave rectify, moving-average over 2^WIN_LOG2 samples, decimate by DECIM.
//  Buffers envelope samples in a small output FIFO with valid/ready to the scan-conversion/display stage.
// PARAMETERS
//  LINE_LEN   24100  RF samples per scanline; line ends after sample index LINE_LEN-1
//  WIN_LOG2   3      log2 of moving-average window length WIN (1..6)
//  DECIM      8      output one envelope sample every DECIM input samples (>=1)
//  FIFO_DEPTH 16     output FIFO entries (power of 2, >=2)
//  DC_SHIFT   6      DC-tracker IIR shift (DC_REMOVE_EN only)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high
//  rf_in      in   16  signed RF sample
//  rf_valid   in   1   rf_in valid this cycle (no backpressure upstream)
//  line_start in   1   qualified by rf_valid; marks sample index 0 of a line
//  out_data   out  16  unsigned envelope sample (FIFO head)
//  out_valid  out  1   FIFO non-empty
//  out_ready  in   1   pop when out_valid&&out_ready
//  line_done  out  1   1-cycle pulse on acceptance of sample LINE_LEN-1
//  overflow   out  1   sticky: a push was dropped on full FIFO; cleared only by reset
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, line_done=0, overflow=0, busy=0; FIFO empty; state IDLE; sum, counters, DC estimate = 0.
//  FSM IDLE->FILL on rf_valid&&line_start (that sample is index 0). FILL->RUN when WIN samples accepted.
//   RUN/FILL->IDLE when sample LINE_LEN-1 accepted (line_done pulses next cycle). rf_valid in IDLE without line_start: ignored.
//   line_start during FILL/RUN: restart line (sample idx 0, fill cnt 0, sum 0, decim cnt 0, DC estimate kept); FIFO untouched.
//  Rectify: a=|x|; x=-32768 saturates to 32767. a is unsigned 15 bits.
//  Window: circular buffer of WIN entries; sum width 15+WIN_LOG2, never overflows.
//   FILL: sum+=a. RUN: sum+=a-oldest. Buffer need not be cleared on restart (FILL never subtracts).
//  Mean = sum>>WIN_LOG2 (truncate), zero-extended to 16 bits.
//  Output: first push at sample index WIN-1, then every DECIM accepted samples; no push past line end.
//  Latency: sample accepted at cycle N -> FIFO push at N+2 -> out_valid at N+3 if FIFO was empty.
//  FIFO: simultaneous push+pop on full is allowed (no drop); push on full without pop -> drop, overflow<=1.
//   out_data stable while out_valid&&!out_ready. Pop on empty ignored.
//  Reset mid-line: all in-flight samples discarded, FIFO flushed, back to IDLE.
// CONFIGURATION
//  DC_REMOVE_EN defined: x = rf_in - dc (saturated to 16-bit signed); dc += (rf_in-dc)>>>DC_SHIFT each accepted sample;
//   dc 16+DC_SHIFT fractional-extended, reset to 0, persists across lines; adds 1 cycle (push at N+3).
//  DC_REMOVE_EN undefined: x = rf_in; no DC register; latency as above.
// STRUCTURE
//  Package rf_pkg: RF_W=16, ENV_W=16, LINE_LEN_DEFAULT=24100, env_state_t {IDLE,FILL,RUN}, abs_sat() function.
//  Sub-module env_out_fifo (sync FIFO, DEPTH/WIDTH params, push/pop/full/empty); rest inline.
// TESTING (WIN_LOG2=2, DECIM=2, LINE_LEN=16, FIFO_DEPTH=4 unless noted)
//  1 line_start + 16x rf_in=-100, out_ready=1 -> 7 outputs =100 at sample idx 3,5,..,15; line_done once; busy drops.
//  2 16x rf_in=-32768 -> every output = 32767; 16x +32767 -> 32767.
//  3 out_ready=0, test 1 stimulus -> 4 entries held (all 100), overflow=1; after drain out_valid=0, overflow stays 1.
//  4 line_start again at idx 6 -> restart; next output only after 4 more samples; no stale window data.
//  5 reset asserted at idx 9 with FIFO non-empty -> next cycle out_valid=0, busy=0; later samples w/o line_start ignored.
//  6 DC_REMOVE_EN, DC_SHIFT=4, LINE_LEN=256: constant rf_in=1000 -> last output of line <=2.

Source files
------------

// File: rtl/rf_pkg.sv
// ============================================================================
// Module  : rf_pkg
// Brief   : Shared widths, FSM state type and rectifier helper for the RF
//           envelope detector.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package rf_pkg;
  localparam int RF_W             = 16;
  localparam int ENV_W            = 16;
  localparam int LINE_LEN_DEFAULT = 24100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } env_state_t;

  // |x| with the most negative code clamped so the result fits 15 bits.
  function automatic logic [14:0] abs_sat(input logic signed [RF_W-1:0] x);
    if (x == -16'sd32768) return 15'h7fff;
    else if (x < 0)       return 15'(-x);
    else                  return 15'(x);
  endfunction
endpackage

`default_nettype wire

// File: rtl/env_out_fifo.sv
// ============================================================================
// Module  : env_out_fifo
// Brief   : Synchronous FIFO; push on full is accepted only with a pop.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module env_out_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop, w_do_push;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rd_data   = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

`default_nettype wire

// File: rtl/rf_envelope_detect.sv
// ============================================================================
// Module  : rf_envelope_detect
// Brief   : Rectify, moving-average and decimate one RF scanline into an
//           output FIFO. Optional DC removal via macro DC_REMOVE_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rf_envelope_detect
  import rf_pkg::*;
#(
  parameter int LINE_LEN   = LINE_LEN_DEFAULT,
  parameter int WIN_LOG2   = 3,
  parameter int DECIM      = 8,
  parameter int FIFO_DEPTH = 16
`ifdef DC_REMOVE_EN
  ,parameter int DC_SHIFT  = 6
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [RF_W-1:0] rf_in,
  input  logic                   rf_valid,
  input  logic                   line_start,
  output logic [ENV_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   line_done,
  output logic                   overflow,
  output logic                   busy
);
  localparam int WIN = 1 << WIN_LOG2;
  localparam int SW  = 15 + WIN_LOG2;
  localparam int IW  = $clog2(LINE_LEN + 1);
  localparam int DW  = (DECIM > 1) ? $clog2(DECIM) : 1;

  env_state_t r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx;
  logic [DW-1:0] r_dcnt;
  logic w_restart, w_acc, w_last, w_fill, w_emit;

  assign w_restart = rf_valid && line_start;
  assign w_acc     = rf_valid && (line_start || (r_state != IDLE));
  assign w_idx     = w_restart ? '0 : r_idx;
  assign w_last    = (w_idx == IW'(LINE_LEN - 1));
  assign w_fill    = w_restart || (r_state == FILL);
  assign w_emit    = (w_idx == IW'(WIN - 1)) ||
                     (!w_fill && (r_dcnt == DW'(DECIM - 1)));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    if (w_acc) begin
      if (w_last)                      w_state_nxt = IDLE;
      else if (w_idx >= IW'(WIN - 1))  w_state_nxt = RUN;
      else                             w_state_nxt = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_dcnt    <= '0;
      line_done <= 1'b0;
    end else begin
      line_done <= w_acc && w_last;
      if (w_acc) begin
        r_idx  <= w_idx + IW'(1);
        r_dcnt <= (w_emit || w_fill) ? '0 : r_dcnt + DW'(1);
      end
    end
  end

  // Pre-stage: raw sample plus control flags feeding the rectifier.
  logic                   w_p_valid, w_p_first, w_p_fill, w_p_emit;
  logic signed [RF_W-1:0] w_p_x;

`ifdef DC_REMOVE_EN
  localparam int FW = RF_W + DC_SHIFT;

  logic signed [FW-1:0]   r_dc;
  logic signed [FW:0]     w_dc_err;
  logic signed [RF_W:0]   w_diff;
  logic signed [RF_W-1:0] w_x_sat;
  logic                   r_p_valid, r_p_first, r_p_fill, r_p_emit;
  logic signed [RF_W-1:0] r_p_x;

  assign w_diff   = {rf_in[RF_W-1], rf_in} -
                    {r_dc[FW-1], r_dc[FW-1:DC_SHIFT]};
  assign w_x_sat  = (w_diff[RF_W] != w_diff[RF_W-1]) ?
                    (w_diff[RF_W] ? -16'sd32768 : 16'sd32767) : w_diff[RF_W-1:0];
  assign w_dc_err = $signed({rf_in[RF_W-1], rf_in, {DC_SHIFT{1'b0}}}) -
                    $signed({r_dc[FW-1], r_dc});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dc      <= '0;
      r_p_valid <= 1'b0;
      r_p_first <= 1'b0;
      r_p_fill  <= 1'b0;
      r_p_emit  <= 1'b0;
      r_p_x     <= '0;
    end else begin
      r_p_valid <= w_acc;
      r_p_first <= w_restart;
      r_p_fill  <= w_fill;
      r_p_emit  <= w_emit;
      if (w_acc) begin
        r_p_x <= w_x_sat;
        r_dc  <= r_dc + FW'($signed(w_dc_err[FW:DC_SHIFT]));
      end
    end
  end

  assign w_p_valid = r_p_valid;
  assign w_p_first = r_p_first;
  assign w_p_fill  = r_p_fill;
  assign w_p_emit  = r_p_emit;
  assign w_p_x     = r_p_x;
`else
  assign w_p_valid = w_acc;
  assign w_p_first = w_restart;
  assign w_p_fill  = w_fill;
  assign w_p_emit  = w_emit;
  assign w_p_x     = rf_in;
`endif

  logic          r_s1_valid, r_s1_first, r_s1_fill, r_s1_emit;
  logic [14:0]   r_s1_a;
  logic [SW-1:0] r_sum;
  logic [14:0]   r_wbuf [WIN];
  logic [WIN_LOG2-1:0] r_wptr;
  logic          r_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_fill  <= 1'b0;
      r_s1_emit  <= 1'b0;
      r_s1_a     <= '0;
      r_sum      <= '0;
      r_wptr     <= '0;
      r_push     <= 1'b0;
    end else begin
      r_s1_valid <= w_p_valid;
      r_s1_first <= w_p_first;
      r_s1_fill  <= w_p_fill;
      r_s1_emit  <= w_p_emit;
      r_s1_a     <= abs_sat(w_p_x);
      r_push     <= r_s1_valid && r_s1_emit;
      if (r_s1_valid) begin
        r_wptr <= r_wptr + 1'b1;
        if (r_s1_first)     r_sum <= SW'(r_s1_a);
        else if (r_s1_fill) r_sum <= r_sum + SW'(r_s1_a);
        else                r_sum <= r_sum + SW'(r_s1_a) - SW'(r_wbuf[r_wptr]);
      end
    end
  end

  // Window contents never need clearing: FILL samples only add.
  always_ff @(posedge clk) begin
    if (r_s1_valid) r_wbuf[r_wptr] <= r_s1_a;
  end

  logic [ENV_W-1:0] w_mean;
  logic             w_full, w_empty;

  assign w_mean    = {1'b0, r_sum[SW-1:WIN_LOG2]};
  assign out_valid = !w_empty;

  env_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENV_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (r_push),
    .wr_data (w_mean),
    .pop     (out_ready),
    .rd_data (out_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset)                              overflow <= 1'b0;
    else if (r_push && w_full && !out_ready) overflow <= 1'b1;
  end
endmodule

`default_nettype wire

// File: tb/tb_rf_envelope_detect.sv
// ============================================================================
// Module  : tb_rf_envelope_detect
// Brief   : Directed bench with a per-cycle reference model of the envelope
//           detector and output FIFO.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_rf_envelope_detect;
  localparam int LINE_LEN = 16;
  localparam int WIN_LOG2 = 2;
  localparam int WIN      = 4;
  localparam int DECIM    = 2;
  localparam int DEPTH    = 4;

  logic               clk, reset, rf_valid, line_start, out_ready;
  logic signed [15:0] rf_in;
  logic [15:0]        out_data;
  logic               out_valid, line_done, overflow, busy;

  rf_envelope_detect #(
    .LINE_LEN   (LINE_LEN),
    .WIN_LOG2   (WIN_LOG2),
    .DECIM      (DECIM),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rf_in      (rf_in),
    .rf_valid   (rf_valid),
    .line_start (line_start),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .line_done  (line_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: line-level averaging from the list of rectified
  // samples, a two-cycle push delay line, and a bounded queue for the FIFO.
  int mq[$];
  int av[$];
  bit dl_v[2];
  int dl_d[2];
  bit in_line, exp_ovf, exp_ld;
  int idx;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete(); av.delete();
        dl_v = '{0, 0}; dl_d = '{0, 0};
        in_line = 0; exp_ovf = 0; exp_ld = 0; idx = 0;
      end else begin
        bit pop, pv, nv;
        int pd, nd, a, s;
        pop = (mq.size() > 0) && out_ready;
        pv = dl_v[0]; pd = dl_d[0];
        if (pop) void'(mq.pop_front());
        if (pv) begin
          if (mq.size() < DEPTH) mq.push_back(pd);
          else exp_ovf = 1;
        end
        nv = 0; nd = 0; exp_ld = 0;
        if (rf_valid && (line_start || in_line)) begin
          if (line_start) begin idx = 0; av.delete(); end
          a = int'(rf_in);
          if (a < 0) a = -a;
          if (a > 32767) a = 32767;
          av.push_back(a);
          if (idx >= WIN - 1 && ((idx - (WIN - 1)) % DECIM) == 0) begin
            s = 0;
            for (int k = 0; k < WIN; k++) s += av[av.size() - 1 - k];
            nv = 1; nd = s / WIN;
          end
          if (idx == LINE_LEN - 1) begin in_line = 0; exp_ld = 1; end
          else in_line = 1;
          idx++;
        end
        dl_v[0] = dl_v[1]; dl_d[0] = dl_d[1];
        dl_v[1] = nv;      dl_d[1] = nd;
      end
    end
  end

  int got[$];
  int ld_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("out_valid", int'(out_valid), int'(mq.size() > 0));
        check("out_data", int'(out_data), (mq.size() > 0) ? mq[0] : 0);
        check("overflow", int'(overflow), int'(exp_ovf));
        check("busy", int'(busy), int'(in_line));
        check("line_done", int'(line_done), int'(exp_ld));
        if (out_valid && out_ready) got.push_back(int'(out_data));
        if (line_done) ld_cnt++;
      end
    end
  end

  task automatic send(input logic signed [15:0] x, input bit ls);
    rf_in = x; rf_valid = 1'b1; line_start = ls;
    @(posedge clk); #1;
    rf_valid = 1'b0; line_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_line(input logic signed [15:0] x, input int n);
    send(x, 1'b1);
    for (int i = 1; i < n; i++) send(x, 1'b0);
  endtask

  initial begin
    reset = 1'b1; rf_in = '0; rf_valid = 1'b0; line_start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;
    idle(2);
    reset = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);

    // Test 1: constant -100 line, always ready
    got.delete(); ld_cnt = 0;
    send_line(-16'sd100, LINE_LEN);
    idle(8);
    check("t1_count", got.size(), 7);
    foreach (got[i]) check("t1_value", got[i], 100);
    check("t1_line_done", ld_cnt, 1);
    check("t1_busy", int'(busy), 0);

    // Test 2: saturating extremes
    got.delete();
    send_line(-16'sd32768, LINE_LEN);
    send_line(16'sd32767, LINE_LEN);
    idle(8);
    check("t2_count", got.size(), 14);
    foreach (got[i]) check("t2_value", got[i], 32767);

    // Test 3: stalled consumer overflows the FIFO
    got.delete(); out_ready = 1'b0;
    send_line(-16'sd100, LINE_LEN);
    idle(6);
    check("t3_held_valid", int'(out_valid), 1);
    check("t3_overflow", int'(overflow), 1);
    out_ready = 1'b1;
    idle(8);
    check("t3_count", got.size(), 4);
    foreach (got[i]) check("t3_value", got[i], 100);
    check("t3_drained", int'(out_valid), 0);
    check("t3_ovf_sticky", int'(overflow), 1);

    // Test 4: restart at idx 6 with a different amplitude
    got.delete();
    send_line(-16'sd100, 6);
    send_line(16'sd200, LINE_LEN);
    idle(8);
    check("t4_count", got.size(), 9);
    if (got.size() == 9) begin
      check("t4_pre0", got[0], 100);
      check("t4_pre1", got[1], 100);
      for (int i = 2; i < 9; i++) check("t4_post", got[i], 200);
    end

    // Test 5: reset mid-line with FIFO non-empty
    out_ready = 1'b0;
    send_line(-16'sd300, 9);
    check("t5_pre_valid", int'(out_valid), 1);
    reset = 1'b1;
    send(-16'sd300, 1'b0);
    reset = 1'b0;
    check("t5_valid", int'(out_valid), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_ovf_clr", int'(overflow), 0);
    for (int i = 0; i < 5; i++) send(16'sd500, 1'b0);
    idle(4);
    check("t5_ignored_valid", int'(out_valid), 0);
    check("t5_ignored_busy", int'(busy), 0);
    out_ready = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
